// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity modes
// and the 3-sample majority helper used by the oversampling receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line front end: synchronises the asynchronous rxd pin and votes the bit value
// from three consecutive mid-bit samples. The first two samples are captured on
// the strobes; the third is the live synchronised line on the decision tick.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    input  logic samp_lo,
    input  logic samp_mid,
    output logic s_rxd,
    output logic bit_val
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   v_lo;
    logic                   v_mid;

    // Metastability chain; reset to the idle-high line level.
    // NOTE: clocked state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign s_rxd = sync[SYNC_STAGES-1];

    // Hold the first two mid-bit samples until the deciding third sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_lo  <= 1'b1;
            v_mid <= 1'b1;
        end else begin
            if (samp_lo)  v_lo  <= s_rxd;
            if (samp_mid) v_mid <= s_rxd;
        end
    end

    assign bit_val = majority3(v_lo, v_mid, s_rxd);

endmodule

// File: rtl/uart_rx_core.sv
// Oversampling UART receiver: frame FSM, tick/bit counters, shift register,
// parity accumulation and a one-entry valid/ready output buffer with overrun.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 baud_tick,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int MID   = OVERSAMPLE / 2;

    localparam logic [CNT_W-1:0] CNT_LO   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID);
    localparam logic [CNT_W-1:0] CNT_HI   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_t          state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shift;
    logic                 par_acc;
    logic                 pend_perr;
    logic                 pend_ferr;

    logic s_rxd;
    logic bit_val;
    logic active;
    logic samp_lo;
    logic samp_mid;
    logic decide;
    logic bit_end;
    logic frame_done;
    logic par_exp;

    assign active     = (state != ST_IDLE);
    assign samp_lo    = active & en & baud_tick & (cnt == CNT_LO);
    assign samp_mid   = active & en & baud_tick & (cnt == CNT_MID);
    assign decide     = active & en & baud_tick & (cnt == CNT_HI);
    assign bit_end    = active & en & baud_tick & (cnt == CNT_LAST);
    assign frame_done = decide & (state == ST_STOP) & (stop_idx == STOP_LAST);
    assign par_exp    = (PARITY == PAR_ODD) ? ~par_acc : par_acc;
    assign busy       = active;

    uart_rx_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk      (clk),
        .rst      (rst),
        .rxd      (rxd),
        .samp_lo  (samp_lo),
        .samp_mid (samp_mid),
        .s_rxd    (s_rxd),
        .bit_val  (bit_val)
    );

    // Frame FSM with tick counter, bit counters, shift register and pending error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift     <= '0;
            par_acc   <= 1'b0;
            pend_perr <= 1'b0;
            pend_ferr <= 1'b0;
        end else if (!en) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
        end else begin
            if (active && baud_tick) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    // The detecting tick is count 0, so the following tick is count 1.
                    if (baud_tick && !s_rxd) begin
                        state     <= ST_START;
                        cnt       <= CNT_W'(1);
                        bit_idx   <= '0;
                        stop_idx  <= 1'b0;
                        par_acc   <= 1'b0;
                        pend_perr <= 1'b0;
                        pend_ferr <= 1'b0;
                    end
                end
                ST_START: begin
                    if (decide && bit_val) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else if (bit_end) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (decide) begin
                        shift   <= {bit_val, shift[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ bit_val;
                    end
                    if (bit_end) begin
                        if (bit_idx == IDX_LAST) begin
                            state <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (decide && (bit_val != par_exp)) pend_perr <= 1'b1;
                    if (bit_end) state <= ST_STOP;
                end
                ST_STOP: begin
                    if (decide) begin
                        if (!bit_val) pend_ferr <= 1'b1;
                        // Return mid-bit on the last stop bit so a back-to-back start edge is seen.
                        if (stop_idx == STOP_LAST) begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end
                    if (bit_end) stop_idx <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One-entry output buffer: load on completion when free or being drained, else flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shift;
                    parity_err <= pend_perr;
                    frame_err  <= pend_ferr | ~bit_val;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Bench for uart_rx_core (8 data bits, even parity, 1 stop, 16x oversampling).
// Stimulus pushes the expected word into a queue; a separate monitor pops and
// compares each word the DUT presents.
module tb_uart_rx_core;

    localparam int BIT_CLK = 64;  // 16 ticks per bit, one tick every 4 clk

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       baud_tick;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   checks   = 0;
    int   failures = 0;
    int   ovr_seen = 0;
    int   exp_ovr  = 0;
    int   tick_div = 0;
    exp_t exp_q[$];

    logic       shown;
    logic [9:0] held;
    exp_t       got_exp;

    uart_rx_core #(
        .DATA_BITS   (8),
        .OVERSAMPLE  (16),
        .PARITY      (1),
        .STOP_BITS   (1),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .baud_tick  (baud_tick),
        .rxd        (rxd),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tick_div  = (tick_div == 3) ? 0 : tick_div + 1;
            baud_tick = (tick_div == 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Reference: even parity means the parity bit equals the XOR of the data bits.
    function automatic exp_t model(input logic [7:0] d, input logic par_bit, input logic stop_bit);
        exp_t m;
        m.data = d;
        m.perr = (par_bit != ^d);
        m.ferr = !stop_bit;
        return m;
    endfunction

    task automatic hold(input logic v, input int n);
        rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // Start the frame on the negedge right after a baud tick.
    task automatic align();
        do @(posedge clk); while (!baud_tick);
        @(negedge clk);
    endtask

    // abort_kind: 0 none, 1 drop en, 2 assert rst; applied 16 clk into bit abort_idx.
    task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                              input int glitch_idx, input int abort_idx, input int abort_kind);
        logic [10:0] bits;
        bits = {stop_bit, par_bit, d, 1'b0};
        align();
        for (int i = 0; i < 11; i++) begin
            if (i == glitch_idx) begin
                hold(bits[i], 32);
                hold(!bits[i], 4);
                hold(bits[i], 28);
            end else if (i == abort_idx) begin
                hold(bits[i], 16);
                if (abort_kind == 1) en = 1'b0;
                else rst = 1'b1;
                @(negedge clk);
                check("abort_busy", 32'(busy), 32'd0);
                if (abort_kind == 2) begin
                    check("rst_rx_data", 32'(rx_data), 32'd0);
                    check("rst_rx_valid", 32'(rx_valid), 32'd0);
                    check("rst_flags", {29'd0, parity_err, frame_err, overrun}, 32'd0);
                end
                hold(bits[i], BIT_CLK - 17);
            end else begin
                hold(bits[i], BIT_CLK);
            end
        end
        if (!stop_bit) hold(1'b1, BIT_CLK);
        hold(1'b1, 8);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                                input int glitch_idx);
        exp_q.push_back(model(d, par_bit, stop_bit));
        send_frame(d, par_bit, stop_bit, glitch_idx, -1, 0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare each newly presented word, then require it to stay stable until accepted.
    initial begin
        shown = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (overrun) ovr_seen++;
            if (rx_valid) begin
                if (!shown) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_word: got data 0x%0h required no rx_valid", rx_data);
                    end else begin
                        got_exp = exp_q.pop_front();
                        check("rx_data", 32'(rx_data), 32'(got_exp.data));
                        check("parity_err", 32'(parity_err), 32'(got_exp.perr));
                        check("frame_err", 32'(frame_err), 32'(got_exp.ferr));
                    end
                    shown = 1'b1;
                    held  = {rx_data, parity_err, frame_err};
                end else begin
                    check("held_stable", 32'({rx_data, parity_err, frame_err}), 32'(held));
                end
                if (rx_ready) shown = 1'b0;
            end else begin
                shown = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        int         g;

        rst = 1'b1; en = 1'b1; rxd = 1'b1; rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Clean frame with correct parity.
        expect_frame(8'hA5, ^8'hA5, 1'b1, -1);
        drain();

        // Parity error, then correct parity.
        expect_frame(8'h07, 1'b0, 1'b1, -1);
        expect_frame(8'h07, 1'b1, 1'b1, -1);
        drain();

        // Framing error followed by recovery.
        expect_frame(8'hC3, ^8'hC3, 1'b0, -1);
        expect_frame(8'h3C, ^8'h3C, 1'b1, -1);
        drain();

        // False start: line low for 4 ticks only.
        align();
        hold(1'b0, 16);
        hold(1'b1, 4);
        check("false_start_busy_mid", 32'(busy), 32'd1);
        hold(1'b1, 28);
        check("false_start_busy_end", 32'(busy), 32'd0);
        hold(1'b1, BIT_CLK * 2);

        // Overrun: second frame dropped while the buffer is held.
        rx_ready = 1'b0;
        expect_frame(8'h11, ^8'h11, 1'b1, -1);
        send_frame(8'h22, ^8'h22, 1'b1, -1, -1, 0);
        exp_ovr++;
        check("overrun_count", 32'(ovr_seen), 32'(exp_ovr));
        check("overrun_rx_valid", 32'(rx_valid), 32'd1);
        check("overrun_rx_data", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("accept_rx_valid_drop", 32'(rx_valid), 32'd0);
        drain();

        // Single flipped sample inside a data bit.
        expect_frame(8'h5A, ^8'h5A, 1'b1, 4);
        expect_frame(8'hF0, ^8'hF0, 1'b1, 1);
        drain();

        // en dropped mid-DATA: frame discarded.
        send_frame(8'h96, ^8'h96, 1'b1, -1, 4, 1);
        en = 1'b1;
        repeat (20) @(negedge clk);
        check("en_abort_no_word", 32'(rx_valid), 32'd0);

        // rst mid-frame: all outputs at reset values.
        send_frame(8'h69, ^8'h69, 1'b1, -1, 5, 2);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_abort_no_word", 32'(rx_valid), 32'd0);

        // Randomised frames with occasional parity/stop errors and glitches.
        for (int n = 0; n < 24; n++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 4) == 0) ? !(^d) : ^d;
            s = ($urandom_range(0, 5) != 0);
            g = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(1, 8));
            expect_frame(d, p, s, g);
        end
        drain();

        check("final_overrun_count", 32'(ovr_seen), 32'(exp_ovr));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
